// File: rtl/br_pkg.sv
// br_pkg: shared FSM state, queue entry layout and default tag width for branch_resolve
package br_pkg;
  localparam int TAG_W = 4;
  typedef enum logic {RUN, FLUSH} br_state_e;
  typedef struct packed {
    logic             taken;
    logic [1:0]       state;
    logic [TAG_W-1:0] tag;
  } br_entry_t;
endpackage

// File: rtl/br_fifo.sv
// br_fifo: circular buffer of outstanding predictions with push/pop/clear and head output
module br_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  assign head = mem[rptr];
  // pointers and occupancy; clear rewinds both pointers to slot 0
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // entry storage needs no reset; occupancy says which slots are live
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= din;
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: in-order prediction queue, resolve/mispredict/flush FSM; BR_STATS_EN adds br_total/br_miss
module branch_resolve
  import br_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = br_pkg::TAG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic [1:0]                 pred_state,
  input  logic [TAG_W-1:0]           pred_tag,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       out_valid,
  output logic                       out_mispredict,
  output logic [TAG_W-1:0]           out_tag,
  output logic [1:0]                 out_state,
  output logic                       flush,
  output logic                       res_err,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef BR_STATS_EN
  ,
  output logic [7:0]                 br_total,
  output logic [7:0]                 br_miss
`endif
);
  localparam int EW = 3 + TAG_W;
  br_state_e state;
  logic [EW-1:0] head;
  logic h_taken;
  logic [1:0] h_state;
  logic [TAG_W-1:0] h_tag;
  logic accept, mis, push;
  assign {h_taken, h_state, h_tag} = head;
  assign pred_ready = (state == RUN) && (32'(count) != DEPTH);
  assign accept = res_valid && (state == RUN) && (count != '0);
  assign mis = accept && (h_taken != res_taken);
  assign push = pred_valid && pred_ready;
  br_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push && !mis),
    .pop(accept && !mis),
    .clear(mis),
    .din({pred_taken, pred_state, pred_tag}),
    .head(head),
    .count(count)
  );
  // FSM and registered resolution outputs; a mispredict spends one cycle in FLUSH
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      out_valid      <= 1'b0;
      out_mispredict <= 1'b0;
      out_tag        <= '0;
      out_state      <= '0;
      flush          <= 1'b0;
      res_err        <= 1'b0;
    end else begin
      state          <= mis ? FLUSH : RUN;
      out_valid      <= accept;
      out_mispredict <= mis;
      flush          <= mis;
      res_err        <= res_valid && !accept;
      if (accept) begin
        out_tag   <= h_tag;
        out_state <= h_state;
      end
    end
  end
`ifdef BR_STATS_EN
  // saturating accuracy statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      br_total <= '0;
      br_miss  <= '0;
    end else begin
      if (accept && br_total != 8'hff) br_total <= br_total + 8'd1;
      if (mis && br_miss != 8'hff) br_miss <= br_miss + 8'd1;
    end
  end
`endif
endmodule
